// File: rtl/demux_pkg.sv
// Shared types and helpers for the demux sequencer: FSM state, channel
// geometry and the round-robin channel search used by the pointer.
package demux_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_e;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // Next unmasked channel after ptr, wrapping; ptr itself if it is the only
    // unmasked one, and ptr unchanged if every channel is masked.
    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ptr,
                                                 input logic [NUM_CH-1:0] mask);
        logic [SEL_W-1:0] cand;
        logic [SEL_W-1:0] result;
        result = ptr;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = ptr + SEL_W'(i);
            if (!mask[cand]) begin
                result = cand;
            end
        end
        return result;
    endfunction

    // Highest unmasked channel, where a frame ends (0 when all are masked).
    function automatic logic [SEL_W-1:0] last_ch(input logic [NUM_CH-1:0] mask);
        logic [SEL_W-1:0] result;
        result = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!mask[i]) begin
                result = SEL_W'(i);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/demux_rr_ptr.sv
// Round-robin channel pointer for the demux sequencer. Skips masked
// channels, restarts at the lowest unmasked channel after reset or clear,
// and flags whether the current / next channel closes a frame.
module demux_rr_ptr
    import demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              advance_i,
    input  logic [NUM_CH-1:0] mask_i,
    output logic [SEL_W-1:0]  ptr_o,
    output logic [SEL_W-1:0]  nextPtr_o,
    output logic              isLast_o,
    output logic              nextIsLast_o,
    output logic              allMasked_o
);

    logic [SEL_W-1:0] ptr_q;
    logic             restart_q;
    logic [SEL_W-1:0] lastCh;

    // While restart_q is set the pointer tracks the lowest unmasked channel,
    // so a mask change before the first bit is still honoured.
    assign ptr_o        = restart_q ? next_ch(SEL_W'(NUM_CH - 1), mask_i) : ptr_q;
    assign nextPtr_o    = next_ch(ptr_o, mask_i);
    assign lastCh       = last_ch(mask_i);
    assign isLast_o     = (ptr_o == lastCh);
    assign nextIsLast_o = (nextPtr_o == lastCh);
    assign allMasked_o  = &mask_i;

    // Pointer register: restart on reset/clear, step on each finished bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            restart_q <= 1'b1;
        end else if (clr_i) begin
            ptr_q     <= '0;
            restart_q <= 1'b1;
        end else if (advance_i) begin
            ptr_q     <= nextPtr_o;
            restart_q <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_sequencer.sv
// Upstream sequencer for the 1-to-4 demux: takes a serial bit stream on a
// valid/ready handshake and drives each bit on d with s stepping
// round-robin, holding every bit HOLD_CYCLES clocks and pulsing frame_done
// on the last cycle of the frame-closing channel. Channel count is fixed at
// 4 by demux_pkg.
// Optional build macro DEMUX_SEQ_MASK_EN adds the ch_mask port so channels
// can be skipped; without it the rotation is a strict 0..3.
module demux_sequencer
    import demux_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    input  logic              in_data,
`ifdef DEMUX_SEQ_MASK_EN
    input  logic [NUM_CH-1:0] ch_mask,
`endif
    output logic              in_ready,
    output logic              d,
    output logic [SEL_W-1:0]  s,
    output logic              out_valid,
    output logic              frame_done
);

    localparam int             HCW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);
    localparam bit             SINGLE    = (HOLD_CYCLES == 1);

    state_e            state_q;
    logic [HCW-1:0]    holdCnt_q;
    logic              d_q;
    logic [SEL_W-1:0]  s_q;
    logic              outValid_q;
    logic              frameDone_q;
    logic              ready_q;

    logic [NUM_CH-1:0] maskEff;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  nextPtr;
    logic              ptrIsLast;
    logic              nextIsLast;
    logic              allMasked;
    logic              lastCycle;
    logic              advance;
    logic              accept;

`ifdef DEMUX_SEQ_MASK_EN
    assign maskEff = ch_mask;
`else
    assign maskEff = '0;
`endif

    assign lastCycle = (state_q == DRIVE) && (holdCnt_q == '0);
    assign advance   = lastCycle && !clr;
    assign in_ready  = ready_q && !clr && !allMasked;
    assign accept    = in_valid && in_ready;

    assign d          = d_q;
    assign s          = s_q;
    assign out_valid  = outValid_q;
    assign frame_done = frameDone_q;

    demux_rr_ptr u_ptr (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (clr),
        .advance_i    (advance),
        .mask_i       (maskEff),
        .ptr_o        (ptr),
        .nextPtr_o    (nextPtr),
        .isLast_o     (ptrIsLast),
        .nextIsLast_o (nextIsLast),
        .allMasked_o  (allMasked)
    );

    // Sequencer FSM: load a bit on accept, count its hold time, then either
    // chain straight into the next bit or fall back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            holdCnt_q   <= '0;
            d_q         <= 1'b0;
            s_q         <= '0;
            outValid_q  <= 1'b0;
            frameDone_q <= 1'b0;
            ready_q     <= 1'b0;
        end else if (clr) begin
            state_q     <= IDLE;
            holdCnt_q   <= '0;
            d_q         <= 1'b0;
            s_q         <= '0;
            outValid_q  <= 1'b0;
            frameDone_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= DRIVE;
                        holdCnt_q   <= HOLD_LOAD;
                        d_q         <= in_data;
                        s_q         <= ptr;
                        outValid_q  <= 1'b1;
                        frameDone_q <= SINGLE && ptrIsLast;
                        ready_q     <= SINGLE;
                    end else begin
                        frameDone_q <= 1'b0;
                        ready_q     <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (holdCnt_q != '0) begin
                        holdCnt_q   <= holdCnt_q - HCW'(1);
                        frameDone_q <= (holdCnt_q == HCW'(1)) && (s_q == last_ch(maskEff));
                        ready_q     <= (holdCnt_q == HCW'(1));
                    end else if (accept) begin
                        holdCnt_q   <= HOLD_LOAD;
                        d_q         <= in_data;
                        s_q         <= nextPtr;
                        outValid_q  <= 1'b1;
                        frameDone_q <= SINGLE && nextIsLast;
                        ready_q     <= SINGLE;
                    end else begin
                        state_q     <= IDLE;
                        d_q         <= 1'b0;
                        outValid_q  <= 1'b0;
                        frameDone_q <= 1'b0;
                        ready_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    outValid_q  <= 1'b0;
                    frameDone_q <= 1'b0;
                    ready_q     <= 1'b1;
                end
            endcase
        end
    end

endmodule
